// File: rtl/mux32_to_1.sv
// Single-bit 32:1 mux built as a five-level binary tree of 2:1 stages,
// with a combinational output and a registered copy.
module mux32_to_1 (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [31:0] in,
    input  logic [4:0]  sel,
    output logic        out,
    output logic        out_q
);

    logic [15:0] lvl0;
    logic [7:0]  lvl1;
    logic [3:0]  lvl2;
    logic [1:0]  lvl3;
    logic        lvl4;
    logic        out_d;

    // Each level consumes one select bit, LSB first; the upper input wins on 1.
    always_comb begin
        lvl0 = '0;
        lvl1 = '0;
        lvl2 = '0;
        lvl3 = '0;
        for (int k = 0; k < 16; k++) begin
            lvl0[k] = sel[0] ? in[2*k+1] : in[2*k];
        end
        for (int k = 0; k < 8; k++) begin
            lvl1[k] = sel[1] ? lvl0[2*k+1] : lvl0[2*k];
        end
        for (int k = 0; k < 4; k++) begin
            lvl2[k] = sel[2] ? lvl1[2*k+1] : lvl1[2*k];
        end
        for (int k = 0; k < 2; k++) begin
            lvl3[k] = sel[3] ? lvl2[2*k+1] : lvl2[2*k];
        end
        lvl4 = sel[4] ? lvl3[1] : lvl3[0];
    end

    assign out = lvl4;

    always_comb begin
        out_d = lvl4;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            out_q <= 1'b0;
        end else begin
            out_q <= out_d;
        end
    end

endmodule

// File: tb/tb_mux32_to_1.sv
// Scoreboard bench for mux32_to_1: comb sweeps plus registered/reset checks.
module tb_mux32_to_1;

    logic        clk;
    logic        reset_n;
    logic [31:0] in;
    logic [4:0]  sel;
    logic        out;
    logic        out_q;

    int total = 0;
    int bad   = 0;

    logic sb_q[$];

    mux32_to_1 dut (
        .clk     (clk),
        .reset_n (reset_n),
        .in      (in),
        .sel     (sel),
        .out     (out),
        .out_q   (out_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic got, input logic exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%b exp=%b (in=%h sel=%0d)",
                     tag, got, exp, in, sel);
        end
    endtask

    // Drive a combinational vector and queue the model's expectation.
    task automatic drive(input logic [31:0] v, input logic [4:0] s);
        logic [31:0] tmp;
        tmp = v;
        in  = v;
        sel = s;
        sb_q.push_back(tmp[s]);
    endtask

    task automatic pop_chk(input string tag, input logic got);
        logic e;
        if (sb_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL %s: got=%b exp=<empty scoreboard>", tag, got);
        end else begin
            e = sb_q.pop_front();
            chk(tag, got, e);
        end
    endtask

    initial begin
        logic [31:0] pat;
        logic [31:0] w;

        reset_n = 1'b0;
        in      = 32'hFFFF_FFFF;
        sel     = 5'd0;

        // Reset held across two edges: out_q 0 while comb path still live.
        repeat (2) begin
            @(posedge clk);
            #1;
            chk("rst_out_q", out_q, 1'b0);
            chk("rst_out", out, 1'b1);
        end
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        chk("rel_out_q", out_q, 1'b1);

        // Pattern sweep.
        pat = 32'hA5A5_5A5A;
        for (int s = 0; s < 32; s++) begin
            drive(pat, 5'(s));
            #1;
            pop_chk("pat_sweep", out);
        end

        // Walking one and walking zero.
        for (int j = 0; j < 32; j++) begin
            for (int s = 0; s < 32; s++) begin
                drive(32'd1 << j, 5'(s));
                #1;
                pop_chk("walk1", out);
                chk("walk1_ref", out, (s == j) ? 1'b1 : 1'b0);
                drive(~(32'd1 << j), 5'(s));
                #1;
                pop_chk("walk0", out);
                chk("walk0_ref", out, (s == j) ? 1'b0 : 1'b1);
            end
        end

        // Register-file slices: word j = j, slice i -> out = sel[i].
        for (int i = 0; i < 5; i++) begin
            w = '0;
            for (int j = 0; j < 32; j++) begin
                w[j] = (j >> i) & 1;
            end
            for (int s = 0; s < 32; s++) begin
                logic [4:0] sv;
                sv = 5'(s);
                drive(w, sv);
                #1;
                pop_chk("slice", out);
                chk("slice_sel", out, sv[i]);
            end
        end

        // Select-bit isolation for stage 4 / stage 0 polarity.
        drive(32'h8000_0001, 5'b11111);
        #1;
        pop_chk("iso_31", out);
        chk("iso_31_ref", out, 1'b1);
        drive(32'h8000_0001, 5'b11110);
        #1;
        pop_chk("iso_30", out);
        chk("iso_30_ref", out, 1'b0);
        drive(32'h8000_0001, 5'b00000);
        #1;
        pop_chk("iso_0", out);
        chk("iso_0_ref", out, 1'b1);

        // Registered path: one-cycle latency behind the comb output.
        @(negedge clk);
        drive(32'h0000_0008, 5'd3);
        @(posedge clk);
        #1;
        pop_chk("reg_s3", out_q);
        chk("reg_s3_out", out, 1'b1);
        @(negedge clk);
        sel = 5'd4;
        sb_q.push_back(1'b0);
        #1;
        chk("reg_s4_out", out, 1'b0);
        chk("reg_s4_hold", out_q, 1'b1);
        @(posedge clk);
        #1;
        pop_chk("reg_s4", out_q);

        // Reset mid-operation clears out_q, leaves out alone.
        @(negedge clk);
        drive(32'hFFFF_FFFF, 5'd5);
        @(posedge clk);
        #1;
        pop_chk("pre_rst", out_q);
        @(negedge clk);
        reset_n = 1'b0;
        @(posedge clk);
        #1;
        chk("mid_rst_q", out_q, 1'b0);
        chk("mid_rst_out", out, 1'b1);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        chk("mid_rel_q", out_q, 1'b1);

        if (sb_q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL sb_leftover: got=%0d exp=0", sb_q.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
